int_ctrl: RTL and testbench

Four-source interrupt controller that sequences the CPU's program-counter and stack path when an interrupt is accepted. It sits beside the control unit. It latches rising edges on the four interrupt lines, arbitrates them by fixed priority, and drives the existing stack-push and PC-load paths to save the return address and jump to the selected vector. It then holds off further interrupts until the handler executes a return-from-interrupt.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/prio_enc4.sv | 19 +
 rtl/int_ctrl.sv | 110 +++++++++++
 tb/tb_int_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer states and default vector layout.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PUSH    = 2'd1,
      JUMP    = 2'd2,
      SERVICE = 2'd3
   } state_t;

   localparam int unsigned NUM_IRQ       = 4;
   localparam logic [9:0]  DEF_VEC_BASE  = 10'h3C0;
   localparam int unsigned DEF_VEC_SHIFT = 2;

endpackage

// File: rtl/prio_enc4.sv
// Fixed-priority encoder: bit 0 wins; valid is low when nothing is set.
module prio_enc4 (
   input  logic [3:0] eligible,
   output logic [1:0] idx,
   output logic       valid
);

   // Lowest set bit selects the index.
   always_comb begin
      idx   = 2'd0;
      valid = 1'b1;
      if (eligible[0])      idx = 2'd0;
      else if (eligible[1]) idx = 2'd1;
      else if (eligible[2]) idx = 2'd2;
      else if (eligible[3]) idx = 2'd3;
      else                  valid = 1'b0;
   end

endmodule

// File: rtl/int_ctrl.sv
// Four-source interrupt controller: edge-latches requests, arbitrates by fixed
// priority, then sequences return-address push and vector jump, and blocks
// further interrupts until the handler returns.
module int_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W      = 10,
   parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(DEF_VEC_BASE),
   parameter int unsigned     VEC_SHIFT = DEF_VEC_SHIFT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               ready,
   input  logic [PC_W-1:0]    pc_cur,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_din,
   input  logic               reti,
   output logic               push_ret,
   output logic [PC_W-1:0]    ret_addr,
   output logic               int_take,
   output logic [PC_W-1:0]    vector,
   output logic [NUM_IRQ-1:0] ack,
   output logic               in_service
);

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] pending_nx;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] eligible;
   logic [1:0]         enc_idx;
   logic               enc_valid;
   logic [1:0]         sel_idx;
   logic               accept;
   state_t             state;
   state_t             state_nx;

   assign rise     = irq & ~irq_q;
   assign eligible = pending & mask;

   prio_enc4 u_prio (
      .eligible (eligible),
      .idx      (enc_idx),
      .valid    (enc_valid)
   );

   // Pending update: clear the serviced source at the end of JUMP, a new edge wins.
   always_comb begin
      clr = '0;
      if (state == JUMP) clr[sel_idx] = 1'b1;
      pending_nx = (pending & ~clr) | rise;
   end

   // Edge-detect history, pending latches and mask register.
   always_ff @(posedge clk) begin
      irq_q <= irq;  // also on reset, so lines already high raise no edge
      if (reset) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         pending <= pending_nx;
         if (mask_we) mask <= mask_din;
      end
   end

   // Next-state logic for the take sequence.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (enc_valid && ready) begin
               state_nx = PUSH;
               accept   = 1'b1;
            end
         end
         PUSH:    state_nx = JUMP;
         JUMP:    state_nx = SERVICE;
         SERVICE: if (reti) state_nx = IDLE;
      endcase
   end

   // State register plus selection and return address captured on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sel_idx  <= 2'd0;
         ret_addr <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            sel_idx  <= enc_idx;
            ret_addr <= pc_cur;
         end
      end
   end

   // Strobes decode registered state only; vector wraps at PC_W bits.
   always_comb begin
      push_ret   = (state == PUSH);
      int_take   = (state == JUMP);
      ack        = clr;
      in_service = (state != IDLE);
      vector     = VEC_BASE + (PC_W'(sel_idx) << VEC_SHIFT);
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed stimulus, a cycle-level behavioural model checked
// on every falling edge, and literal expectations at key points.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       ready;
   logic [9:0] pc_cur;
   logic       mask_we;
   logic [3:0] mask_din;
   logic       reti;
   logic       push_ret;
   logic [9:0] ret_addr;
   logic       int_take;
   logic [9:0] vector;
   logic [3:0] ack;
   logic       in_service;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   int_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .ready      (ready),
      .pc_cur     (pc_cur),
      .mask_we    (mask_we),
      .mask_din   (mask_din),
      .reti       (reti),
      .push_ret   (push_ret),
      .ret_addr   (ret_addr),
      .int_take   (int_take),
      .vector     (vector),
      .ack        (ack),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_cnt counts cycles since an interrupt was accepted (0 = none active).
   logic [3:0] m_prev, m_pend, m_mask;
   int         m_cnt, m_src;
   logic [9:0] m_ret;

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic logic [3:0] next_pend(input logic [3:0] p, input logic [3:0] r,
                                            input bit clear, input int src);
      logic [3:0] t;
      t = p;
      if (clear) t[src] = 1'b0;
      return t | r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_prev <= irq;
         m_pend <= '0;
         m_mask <= '0;
         m_cnt  <= 0;
         m_src  <= 0;
         m_ret  <= '0;
      end else begin
         m_prev <= irq;
         if (mask_we) m_mask <= mask_din;
         m_pend <= next_pend(m_pend, irq & ~m_prev, m_cnt == 2, m_src);
         case (m_cnt)
            0: if (ready && (m_pend & m_mask) != 4'd0) begin
                  m_src <= lowest(m_pend & m_mask);
                  m_ret <= pc_cur;
                  m_cnt <= 1;
               end
            1: m_cnt <= 2;
            2: m_cnt <= 3;
            default: if (reti) m_cnt <= 0;
         endcase
      end
   end

   // Compare DUT against the model each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("push_ret", int'(push_ret), int'(m_cnt == 1));
         chk("int_take", int'(int_take), int'(m_cnt == 2));
         chk("ack", int'(ack), (m_cnt == 2) ? (1 << m_src) : 0);
         chk("in_service", int'(in_service), int'(m_cnt != 0));
         chk("ret_addr", int'(ret_addr), int'(m_ret));
         chk("pending", int'(dut.pending), int'(m_pend));
         if (m_cnt == 2) chk("vector", int'(vector), int'(10'(10'h3C0 + m_src * 4)));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_mask(input logic [3:0] m);
      mask_we  = 1'b1;
      mask_din = m;
      cyc(1);
      mask_we  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq = 4'hF; ready = 1'b0; pc_cur = '0;
      mask_we = 1'b0; mask_din = '0; reti = 1'b0;
      cyc(1);
      chk_en = 1'b1;
      cyc(2);
      chk("rst_ret_addr", int'(ret_addr), 0);
      chk("rst_vector", int'(vector), 'h3C0);
      chk("rst_in_service", int'(in_service), 0);
      chk("rst_ack", int'(ack), 0);

      // Lines high through reset must not look like edges.
      reset = 1'b0; ready = 1'b1;
      set_mask(4'hF);
      cyc(3);
      chk("hi_push", int'(push_ret), 0);
      chk("hi_state", int'(dut.state), 0);
      chk("hi_pend", int'(dut.pending), 0);
      irq = 4'h0;
      cyc(2);

      // Single source 2.
      set_mask(4'b0100);
      irq = 4'b0100; pc_cur = 10'h055;
      cyc(1);
      chk("s_pend", int'(dut.pending), 'b0100);
      chk("s_idle", int'(in_service), 0);
      cyc(1);
      irq = 4'h0; pc_cur = 10'h1AA;
      chk("s_push", int'(push_ret), 1);
      chk("s_ret", int'(ret_addr), 'h055);
      cyc(1);
      chk("s_take", int'(int_take), 1);
      chk("s_vec", int'(vector), 'h3C8);
      chk("s_ack", int'(ack), 'b0100);
      cyc(4);
      chk("s_serv", int'(in_service), 1);
      reti = 1'b1;
      cyc(1);
      reti = 1'b0;
      chk("s_done", int'(in_service), 0);

      // Priority: 1 before 3.
      set_mask(4'hF);
      irq = 4'b1010;
      cyc(1);
      irq = 4'h0;
      cyc(2);
      chk("p_vec1", int'(vector), 'h3C4);
      chk("p_ack1", int'(ack), 'b0010);
      cyc(1);
      reti = 1'b1;
      cyc(1);
      reti = 1'b0;
      cyc(1);
      chk("p_push2", int'(push_ret), 1);
      cyc(1);
      chk("p_vec2", int'(vector), 'h3CC);
      chk("p_ack2", int'(ack), 'b1000);
      cyc(1);
      reti = 1'b1;
      cyc(1);
      reti = 1'b0;

      // Masked source, then held off by ready = 0.
      set_mask(4'h0);
      irq = 4'b0001;
      cyc(1);
      chk("m_pend", int'(dut.pending), 'b0001);
      irq = 4'h0;
      cyc(3);
      chk("m_none", int'(in_service), 0);
      ready = 1'b0;
      set_mask(4'b0001);
      cyc(4);
      chk("m_held", int'(push_ret), 0);
      ready = 1'b1;
      cyc(1);
      chk("m_push", int'(push_ret), 1);
      cyc(1);
      chk("m_vec", int'(vector), 'h3C0);
      cyc(1);

      // Edge during service waits for reti.
      set_mask(4'b0101);
      irq = 4'b0100;
      cyc(1);
      irq = 4'h0;
      cyc(2);
      chk("e_noprst", int'(push_ret), 0);
      chk("e_serv", int'(in_service), 1);
      reti = 1'b1;
      cyc(1);
      reti = 1'b0;
      cyc(1);
      chk("e_push", int'(push_ret), 1);
      cyc(1);
      chk("e_vec", int'(vector), 'h3C8);
      cyc(1);
      reti = 1'b1;
      cyc(1);
      cyc(2);  // reti while idle does nothing
      reti = 1'b0;
      chk("e_idle", int'(in_service), 0);

      // Set-wins collision on source 1, then reset during PUSH.
      set_mask(4'hF);
      irq = 4'b0010;
      cyc(1);
      irq = 4'h0;
      cyc(1);
      cyc(1);
      chk("c_take", int'(int_take), 1);
      irq = 4'b0010;
      cyc(1);
      chk("c_pend", int'(dut.pending[1]), 1);
      irq = 4'h0;
      reti = 1'b1;
      cyc(1);
      reti = 1'b0;
      cyc(1);
      chk("c_push", int'(push_ret), 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("r_state", int'(dut.state), 0);
      chk("r_push", int'(push_ret), 0);
      cyc(3);
      chk("r_take", int'(int_take), 0);
      chk("r_serv", int'(in_service), 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
